// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core memory-stage blocks.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmemState_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/dmem_ctl_timeout_cnt.sv
// Loadable down-counter that stops at zero; expired flags the zero count.
module timeout_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] loadVal,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Holding at zero keeps the count from wrapping if enable stays high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/dmem_ctl.sv
// Memory-stage data-memory controller: turns lw/sw into a req/ack bus
// transaction, stalls the pipeline meanwhile, flags misalignment and timeouts.
module dmem_ctl
  import mips_pkg::*;
#(
  parameter int          TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_ME,
  input  logic        MemWrite_ME,
  input  logic [31:0] Addr_ME,
  input  logic [31:0] WrDat_ME,
  output logic [31:0] RdDat_ME,
  output logic        Stall_ME,
  output logic        MemErr_ME,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWrDat,
  input  logic        BusAck,
  input  logic [31:0] BusRdDat
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Counting down from TIMEOUT-1 gives exactly TIMEOUT WAIT cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  dmemState_t state, stateNext;
  logic       acc;
  logic       aligned;
  logic       startXfer;
  logic       expired;

  assign acc       = MemRead_ME | MemWrite_ME;
  assign aligned   = ((Addr_ME & ~WORD_ALIGN_MASK) == 32'h0);
  assign startXfer = (state == IDLE) && acc && aligned;

  timeout_cnt #(
    .WIDTH (CNT_W)
  ) uTimeoutCnt (
    .clk     (clk),
    .reset   (reset),
    .load    (startXfer),
    .enable  ((state == WAIT) && !BusAck),
    .loadVal (CNT_LOAD),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (acc && aligned) stateNext = WAIT;
      WAIT:    if (BusAck || expired) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Reset gates the stall so a mid-transaction reset releases the pipeline at once.
  always_comb begin
    Stall_ME = 1'b0;
    unique case (state)
      IDLE:    Stall_ME = acc && aligned;
      WAIT:    Stall_ME = 1'b1;
      default: Stall_ME = 1'b0;
    endcase
    Stall_ME = Stall_ME & ~reset;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RdDat_ME  <= 32'h0;
      MemErr_ME <= 1'b0;
      BusReq    <= 1'b0;
      BusWe     <= 1'b0;
      BusAddr   <= 32'h0;
      BusWrDat  <= 32'h0;
    end else begin
      MemErr_ME <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc && aligned) begin
            BusReq   <= 1'b1;
            BusWe    <= MemWrite_ME;
            BusAddr  <= Addr_ME & WORD_ALIGN_MASK;
            BusWrDat <= WrDat_ME;
          end else if (acc) begin
            MemErr_ME <= 1'b1;
            if (!MemWrite_ME) RdDat_ME <= ERR_DATA;
          end
        end
        WAIT: begin
          // An ack coinciding with expiry wins: it is checked first.
          if (BusAck) begin
            BusReq <= 1'b0;
            if (!BusWe) RdDat_ME <= BusRdDat;
          end else if (expired) begin
            BusReq    <= 1'b0;
            MemErr_ME <= 1'b1;
            if (!BusWe) RdDat_ME <= ERR_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctl.sv
// Directed bench for dmem_ctl: per-access expected traces in a queue, checked every cycle.
module tb_dmem_ctl;
  import mips_pkg::*;

  localparam int          TIMEOUT  = 15;
  localparam logic [31:0] ERR_DATA = 32'h0000_0000;
  localparam int          EW       = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead_ME = 1'b0;
  logic        MemWrite_ME = 1'b0;
  logic [31:0] Addr_ME = 32'h0;
  logic [31:0] WrDat_ME = 32'h0;
  logic [31:0] RdDat_ME;
  logic        Stall_ME;
  logic        MemErr_ME;
  logic        BusReq;
  logic        BusWe;
  logic [31:0] BusAddr;
  logic [31:0] BusWrDat;
  logic        BusAck = 1'b0;
  logic [31:0] BusRdDat = 32'h0;

  // Expected per-cycle view: {stall, busReq, busWe, memErr, busAddr, busWrDat, rdDat}
  logic [EW-1:0] exp_q[$];

  // Model of the architecturally visible registers.
  logic        mWe = 1'b0;
  logic [31:0] mAddr = 32'h0;
  logic [31:0] mWd = 32'h0;
  logic [31:0] mRd = 32'h0;

  int checks = 0;
  int failures = 0;
  int stallCycles = 0;
  int reqCycles = 0;
  int reqRises = 0;

  dmem_ctl #(
    .TIMEOUT  (TIMEOUT),
    .ERR_DATA (ERR_DATA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .MemRead_ME  (MemRead_ME),
    .MemWrite_ME (MemWrite_ME),
    .Addr_ME     (Addr_ME),
    .WrDat_ME    (WrDat_ME),
    .RdDat_ME    (RdDat_ME),
    .Stall_ME    (Stall_ME),
    .MemErr_ME   (MemErr_ME),
    .BusReq      (BusReq),
    .BusWe       (BusWe),
    .BusAddr     (BusAddr),
    .BusWrDat    (BusWrDat),
    .BusAck      (BusAck),
    .BusRdDat    (BusRdDat)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: one expected entry per driven cycle, compared on the falling edge.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("stall",    32'(Stall_ME),  32'(e[99]));
        chk("busreq",   32'(BusReq),    32'(e[98]));
        chk("buswe",    32'(BusWe),     32'(e[97]));
        chk("memerr",   32'(MemErr_ME), 32'(e[96]));
        chk("busaddr",  BusAddr,        e[95:64]);
        chk("buswrdat", BusWrDat,       e[63:32]);
        chk("rddat",    RdDat_ME,       e[31:0]);
      end
    end
  end

  // Activity counters for transaction-level literal checks.
  initial begin
    logic prevReq;
    prevReq = 1'b0;
    forever begin
      @(negedge clk);
      if (Stall_ME) stallCycles++;
      if (BusReq) reqCycles++;
      if (BusReq && !prevReq) reqRises++;
      prevReq = BusReq;
    end
  end

  // Driver tasks
  task automatic step(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] wd,
                      input logic ack, input logic [31:0] rdat,
                      input logic eStall, input logic eReq, input logic eErr);
    @(posedge clk);
    #1;
    MemRead_ME  = mr;
    MemWrite_ME = mw;
    Addr_ME     = a;
    WrDat_ME    = wd;
    BusAck      = ack;
    BusRdDat    = rdat;
    exp_q.push_back({eStall, eReq, mWe, eErr, mAddr, mWd, mRd});
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, ack, $urandom, 1'b0, 1'b0, 1'b0);
  endtask

  // One memory-stage access; ackAt is the WAIT cycle (1-based) carrying the ack, 0 = none.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                        input int ackAt, input logic [31:0] rdat);
    logic timedOut;
    int   waitN;
    if (a[1:0] != 2'b00) begin
      step(rd, wr, a, wd, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
      if (!wr) mRd = ERR_DATA;
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      return;
    end
    timedOut = (ackAt < 1) || (ackAt > TIMEOUT);
    waitN    = timedOut ? TIMEOUT : ackAt;
    step(rd, wr, a, wd, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    mWe   = wr;
    mAddr = a & 32'hFFFF_FFFC;
    mWd   = wd;
    for (int k = 1; k <= waitN; k++)
      step(rd, wr, a, wd, (k == ackAt), (k == ackAt) ? rdat : ~rdat, 1'b1, 1'b1, 1'b0);
    if (!wr) mRd = timedOut ? ERR_DATA : rdat;
    // A spurious ack with junk data during DONE must be ignored.
    step(rd, wr, a, wd, 1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0, timedOut);
  endtask

  initial begin
    int s0, r0, q0;

    // Reset state
    #11;
    chk("rst_rddat",    RdDat_ME,           32'h0);
    chk("rst_busreq",   32'(BusReq),        32'h0);
    chk("rst_buswe",    32'(BusWe),         32'h0);
    chk("rst_busaddr",  BusAddr,            32'h0);
    chk("rst_buswrdat", BusWrDat,           32'h0);
    chk("rst_memerr",   32'(MemErr_ME),     32'h0);
    chk("rst_stall",    32'(Stall_ME),      32'h0);
    #1 reset = 1'b0;
    idle(2, 1'b1);

    // Load acked in the first WAIT cycle
    s0 = stallCycles;
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'hCAFE_F00D);
    idle(1, 1'b0);
    chk("lw_stall_cycles", 32'(stallCycles - s0), 32'd2);
    chk("lw_rddat",        RdDat_ME,              32'hCAFE_F00D);

    // Store with ack in the fourth WAIT cycle
    s0 = stallCycles;
    access(1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 4, 32'h0);
    idle(1, 1'b0);
    chk("sw_stall_cycles", 32'(stallCycles - s0), 32'd5);
    chk("sw_rddat_kept",   RdDat_ME,              32'hCAFE_F00D);
    chk("sw_buswrdat",     BusWrDat,              32'h1234_5678);

    // Load with no ack: timeout
    q0 = reqCycles;
    access(1'b1, 1'b0, 32'h0000_0300, 32'h0, 0, 32'h0);
    idle(1, 1'b0);
    chk("to_req_cycles", 32'(reqCycles - q0), 32'd15);
    chk("to_rddat",      RdDat_ME,            32'h0);

    // Ack on the very last WAIT cycle counts as success
    access(1'b1, 1'b0, 32'h0000_0400, 32'h0, TIMEOUT, 32'h0BAD_CAFE);
    idle(1, 1'b0);
    chk("late_ack_rddat", RdDat_ME, 32'h0BAD_CAFE);

    // Misaligned load, then misaligned store
    r0 = reqRises;
    access(1'b1, 1'b0, 32'h0000_0102, 32'h0, 1, 32'h0);
    access(1'b0, 1'b1, 32'h0000_0101, 32'hFFFF_FFFF, 1, 32'h0);
    idle(1, 1'b0);
    chk("mis_no_req", 32'(reqRises - r0), 32'd0);
    chk("mis_rddat",  RdDat_ME,           32'h0);

    // Both read and write set behaves as a write
    access(1'b1, 1'b1, 32'h0000_0080, 32'h1111_2222, 1, 32'h9999_9999);
    idle(1, 1'b0);
    chk("rw_is_write", RdDat_ME, 32'h0);

    // Back-to-back lw then sw
    r0 = reqRises;
    s0 = stallCycles;
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1, 32'h0000_AAAA);
    access(1'b0, 1'b1, 32'h0000_0014, 32'h0000_BBBB, 1, 32'h0);
    idle(1, 1'b0);
    chk("b2b_req_count", 32'(reqRises - r0),    32'd2);
    chk("b2b_stalls",    32'(stallCycles - s0), 32'd4);
    chk("b2b_rddat",     RdDat_ME,              32'h0000_AAAA);

    // Reset while in WAIT
    step(1'b1, 1'b0, 32'h0000_0500, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    mWe = 1'b0;
    mAddr = 32'h0000_0500;
    mWd = 32'h0;
    step(1'b1, 1'b0, 32'h0000_0500, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busreq", 32'(BusReq),   32'h0);
    chk("midrst_stall",  32'(Stall_ME), 32'h0);
    MemRead_ME = 1'b0;
    Addr_ME = 32'h0;
    #4 reset = 1'b0;
    mWe = 1'b0;
    mAddr = 32'h0;
    mWd = 32'h0;
    mRd = 32'h0;

    // Spurious ack while idle
    idle(3, 1'b1);
    #1;
    chk("spurious_state", 32'(dut.state), 32'(IDLE));

    // Recovery access after reset
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 2, 32'h7777_0001);
    idle(2, 1'b0);
    repeat (2) @(negedge clk);
    chk("recover_rddat", RdDat_ME, 32'h7777_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
